exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EXE pipeline register outputs and computes the ALU result.
- Resolves branches and reports the redirect to fetch.
- Runs an iterative 32-cycle shift-add multiplier, stalling upstream while it is busy.
- Owns the EXE/MEM pipeline register feeding the memory stage.

Parameters:
- len, 32, width of pc and instruction fields (matches the ID/EXE register).
- MUL_CYCLES, 32, multiplier iterations; must equal the operand width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  ID/EXE register holds a live instruction
- pc  in  len  PC+4 of the instruction
- instruction  in  len  raw instruction, passed through
- wb_en, mem_read, mem_write  in  1 each  control bits from ID/EXE
- branch_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd  in  4  ALU operation
- alu_inp1, alu_inp2, reg2  in  32 each  operands; alu_inp2 is the sign-extended immediate for branches
- dest  in  5  destination register
- stall  out  1  hold ID/EXE and earlier stages (combinational)
- br_taken  out  1  redirect fetch and flush IF/ID and ID/EXE (combinational)
- br_addr  out  32  redirect target (combinational)
- mem_valid, mem_wb_en, mem_mem_read, mem_mem_write  out  1 each  registered to MEM
- mem_alu_result, mem_reg2  out  32 each  registered
- mem_dest  out  5  registered
- mem_pc, mem_instruction  out  len each  registered

Behaviour:
- Reset (sync, active-high): all mem_* outputs are 0, the FSM is IDLE, and the multiplier counter and accumulators are 0.
- Reset overrides everything, including an in-progress multiply, which is discarded.
- exe_cmd encoding: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL, 1100 MUL. Every other code produces result 0.
- Arithmetic wraps mod 2^32; no overflow flag.
- Shift amount is alu_inp2[4:0], applied to alu_inp1.
- MUL result is the low 32 bits of alu_inp1*alu_inp2.
- Single-cycle ops: result is captured into EXE/MEM at the next edge. Latency is 1 cycle and stall=0.
- Branch evaluation (only when in_valid=1 and stall=0):
  - BEZ is taken if alu_inp1==0.
  - BNE is taken if alu_inp1!=reg2.
  - JMP is always taken.
  - br_addr = pc + (alu_inp2<<2), computed mod 2^32.
  - Otherwise br_taken=0. br_addr is don't-care when br_taken=0.
- The branch instruction itself still enters EXE/MEM with its own control bits.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: if in_valid and exe_cmd==MUL, latch the operands, clear the accumulator, set count=0, go to BUSY. stall=1. A bubble enters EXE/MEM (mem_valid=0, wb_en/mem_read/mem_write=0).
  - BUSY: one shift-add iteration per cycle, count++. stall=1 and a bubble enters EXE/MEM. Go to DONE when count reaches MUL_CYCLES-1.
  - DONE: stall=0. The product and the held control fields are captured into EXE/MEM at this edge. Return to IDLE.
  - Timing: stall is high for MUL_CYCLES+1 cycles. The product is visible on mem_alu_result MUL_CYCLES+2 edges after MUL first appears.
  - Back-to-back MUL: the DONE→IDLE edge consumes the next instruction. A second MUL starts a fresh sequence with no extra idle cycle.
- in_valid=0: a bubble enters EXE/MEM and the FSM is unaffected. If the FSM is in BUSY, it continues.
- Inputs are sampled every cycle. Upstream holds them stable while stall=1; the block does not re-check this.
- EXE/MEM passthrough: pc, instruction, reg2, dest and control bits register unchanged when not a bubble. mem_valid = in_valid gated by stall.

Optional Feature:
- MUL_UNIT_EN defined: multiplier FSM present as described.
- MUL_UNIT_EN undefined: no FSM, stall is tied to 0, and MUL (1100) is treated as an unused code (result 0, single-cycle).

Test Plan:
- Reset: assert reset during BUSY (count=10) → next edge all mem_* = 0, stall=0, FSM IDLE.
- ADD alu_inp1=0xFFFFFFFF, alu_inp2=2, dest=5, wb_en=1 → after 1 edge mem_alu_result=0x00000001, mem_dest=5, mem_wb_en=1, mem_valid=1.
- SRA alu_inp1=0x80000000, alu_inp2=0x24 (shamt 4) → mem_alu_result=0xF8000000.
- BNE pc=0x100, alu_inp1=3, reg2=4, alu_inp2=0xFFFFFFFE → br_taken=1, br_addr=0xF8. Same with reg2=3 → br_taken=0.
- MUL 7×0xFFFFFFFF (MUL_UNIT_EN) → stall high 33 cycles, mem_valid=0 throughout. The product 0xFFFFFFF9 appears with mem_valid=1 after edge 34.
- MUL followed immediately by MUL 3×5 → first product, then second product 0x0000000F 34 edges later; no lost instruction.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution, iterative multiplier and the EXE/MEM register.
// Optional multiplier FSM is built when MUL_UNIT_EN is defined.
module exe_stage #(
  parameter int len        = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [len-1:0] pc,
  input  logic [len-1:0] instruction,
  input  logic           wb_en,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     branch_type,
  input  logic [3:0]     exe_cmd,
  input  logic [31:0]    alu_inp1,
  input  logic [31:0]    alu_inp2,
  input  logic [31:0]    reg2,
  input  logic [4:0]     dest,
  output logic           stall,
  output logic           br_taken,
  output logic [31:0]    br_addr,
  output logic           mem_valid,
  output logic           mem_wb_en,
  output logic           mem_mem_read,
  output logic           mem_mem_write,
  output logic [31:0]    mem_alu_result,
  output logic [31:0]    mem_reg2,
  output logic [4:0]     mem_dest,
  output logic [len-1:0] mem_pc,
  output logic [len-1:0] mem_instruction
);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_BEZ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        bubble;

  assign shamt = alu_inp2[4:0];

`ifdef MUL_UNIT_EN
  localparam int CW = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mplier, acc;
  logic [CW-1:0] count;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && exe_cmd == CMD_MUL) begin
          state_nxt = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == CW'(MUL_CYCLES - 1))
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BUSY) begin
        mcand  <= alu_inp1;
        mplier <= alu_inp2;
        acc    <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        acc    <= acc + (mplier[0] ? mcand : 32'd0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_result = '0;
    case (exe_cmd)
      CMD_ADD: alu_result = alu_inp1 + alu_inp2;
      CMD_SUB: alu_result = alu_inp1 - alu_inp2;
      CMD_AND: alu_result = alu_inp1 & alu_inp2;
      CMD_OR:  alu_result = alu_inp1 | alu_inp2;
      CMD_NOR: alu_result = ~(alu_inp1 | alu_inp2);
      CMD_XOR: alu_result = alu_inp1 ^ alu_inp2;
      CMD_SLL: alu_result = alu_inp1 << shamt;
      CMD_SRA: alu_result = 32'($signed(alu_inp1) >>> shamt);
      CMD_SRL: alu_result = alu_inp1 >> shamt;
`ifdef MUL_UNIT_EN
      // Only meaningful in DONE; earlier cycles are bubbled.
      CMD_MUL: alu_result = acc;
`endif
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    if (in_valid && !stall) begin
      unique case (1'b1)
        branch_type == BR_BEZ: br_taken = (alu_inp1 == 32'd0);
        branch_type == BR_BNE: br_taken = (alu_inp1 != reg2);
        branch_type == BR_JMP: br_taken = 1'b1;
        default:               br_taken = 1'b0;
      endcase
    end
  end

  assign br_addr = 32'(pc) + (alu_inp2 << 2);
  assign bubble  = !in_valid || stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid       <= 1'b0;
      mem_wb_en       <= 1'b0;
      mem_mem_read    <= 1'b0;
      mem_mem_write   <= 1'b0;
      mem_alu_result  <= '0;
      mem_reg2        <= '0;
      mem_dest        <= '0;
      mem_pc          <= '0;
      mem_instruction <= '0;
    end else begin
      mem_valid       <= !bubble;
      mem_wb_en       <= wb_en && !bubble;
      mem_mem_read    <= mem_read && !bubble;
      mem_mem_write   <= mem_write && !bubble;
      mem_alu_result  <= alu_result;
      mem_reg2        <= reg2;
      mem_dest        <= dest;
      mem_pc          <= pc;
      mem_instruction <= instruction;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against a behavioural ALU/branch/multiply model.
// Multiplier timing is checked only when MUL_UNIT_EN is defined.
module tb_exe_stage;

`ifdef MUL_UNIT_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc, instruction;
  logic        wb_en, mem_read, mem_write;
  logic [1:0]  branch_type;
  logic [3:0]  exe_cmd;
  logic [31:0] alu_inp1, alu_inp2, reg2;
  logic [4:0]  dest;
  logic        stall, br_taken;
  logic [31:0] br_addr;
  logic        mem_valid, mem_wb_en, mem_mem_read, mem_mem_write;
  logic [31:0] mem_alu_result, mem_reg2;
  logic [4:0]  mem_dest;
  logic [31:0] mem_pc, mem_instruction;

  int vectors = 0;
  int miscompares = 0;

  exe_stage #(.len(32), .MUL_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .pc(pc), .instruction(instruction),
    .wb_en(wb_en), .mem_read(mem_read), .mem_write(mem_write),
    .branch_type(branch_type), .exe_cmd(exe_cmd),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .reg2(reg2), .dest(dest),
    .stall(stall), .br_taken(br_taken), .br_addr(br_addr),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result), .mem_reg2(mem_reg2),
    .mem_dest(mem_dest), .mem_pc(mem_pc),
    .mem_instruction(mem_instruction)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] wide;
    int sh;
    sh = int'(b % 32);
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a * (32'd1 << sh);
      4'd9: begin
        wide = {{32{a[31]}}, a} >> sh;
        return wide[31:0];
      end
      4'd10: return a / (32'd1 << sh);
      4'd12: begin
        wide = 64'(a) * 64'(b);
        return MUL_ON ? wide[31:0] : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic v, input logic [1:0] bt,
                                     input logic [31:0] a,
                                     input logic [31:0] r2);
    if (!v) return 1'b0;
    if (bt == 2'd1) return a == 0;
    if (bt == 2'd2) return a != r2;
    return bt == 2'd3;
  endfunction

  // Called just after a rising edge; returns just after the capturing edge.
  task automatic apply(input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic w,
                       input logic mr, input logic mw,
                       input logic [1:0] bt, input logic [3:0] cmd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [4:0] d);
    logic is_mul, tk;
    int sc;
    in_valid = v; pc = p; instruction = ins;
    wb_en = w; mem_read = mr; mem_write = mw;
    branch_type = bt; exe_cmd = cmd;
    alu_inp1 = a; alu_inp2 = b; reg2 = r2; dest = d;
    is_mul = v && MUL_ON && cmd == 4'd12;
    if (is_mul) begin
      sc = 0;
      while (stall === 1'b1 && sc < 200) begin
        sc++;
        @(posedge clock); #1;
        check("mul_bubble", 32'(mem_valid), 32'd0);
      end
      check("mul_stall_cycles", 32'(sc), 32'd33);
    end else begin
      #3;
      check("stall", 32'(stall), 32'd0);
      tk = ref_taken(v, bt, a, r2);
      check("br_taken", 32'(br_taken), 32'(tk));
      if (tk) check("br_addr", br_addr, p + b * 4);
    end
    @(posedge clock); #1;
    check("mem_valid", 32'(mem_valid), 32'(v));
    check("mem_wb_en", 32'(mem_wb_en), 32'(w & v));
    check("mem_mem_read", 32'(mem_mem_read), 32'(mr & v));
    check("mem_mem_write", 32'(mem_mem_write), 32'(mw & v));
    if (v) begin
      check("mem_alu_result", mem_alu_result, ref_alu(cmd, a, b));
      check("mem_dest", 32'(mem_dest), 32'(d));
      check("mem_pc", mem_pc, p);
      check("mem_reg2", mem_reg2, r2);
      check("mem_instruction", mem_instruction, ins);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_wb"}, 32'(mem_wb_en), 32'd0);
    check({tag, "_rd"}, 32'(mem_mem_read), 32'd0);
    check({tag, "_wr"}, 32'(mem_mem_write), 32'd0);
    check({tag, "_res"}, mem_alu_result, 32'd0);
    check({tag, "_reg2"}, mem_reg2, 32'd0);
    check({tag, "_dest"}, 32'(mem_dest), 32'd0);
    check({tag, "_pc"}, mem_pc, 32'd0);
    check({tag, "_ins"}, mem_instruction, 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  logic [3:0] ops [12];

  initial begin
    ops = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7,
            4'd8, 4'd9, 4'd10, 4'd1, 4'd3, 4'd15};
    reset = 1'b1; in_valid = 1'b0; pc = 0; instruction = 0;
    wb_en = 0; mem_read = 0; mem_write = 0; branch_type = 0;
    exe_cmd = 0; alu_inp1 = 0; alu_inp2 = 0; reg2 = 0; dest = 0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    apply(1, 32'h40, 32'h11, 1, 0, 0, 2'd0, 4'd0,
          32'hFFFFFFFF, 32'd2, 32'd0, 5'd5);
    apply(1, 32'h44, 32'h12, 1, 0, 0, 2'd0, 4'd9,
          32'h80000000, 32'h24, 32'd0, 5'd6);
    check("sra_value", mem_alu_result, 32'hF8000000);
    apply(1, 32'h100, 32'h13, 0, 0, 0, 2'd2, 4'd0,
          32'd3, 32'hFFFFFFFE, 32'd4, 5'd0);
    apply(1, 32'h100, 32'h14, 0, 0, 0, 2'd2, 4'd0,
          32'd3, 32'hFFFFFFFE, 32'd3, 5'd0);
    apply(1, 32'h200, 32'h15, 1, 0, 0, 2'd0, 4'd12,
          32'd7, 32'hFFFFFFFF, 32'd9, 5'd7);
    apply(1, 32'h204, 32'h16, 1, 0, 0, 2'd0, 4'd12,
          32'd3, 32'd5, 32'd1, 5'd8);
    apply(0, 32'h208, 32'h17, 1, 1, 1, 2'd3, 4'd12,
          32'd3, 32'd5, 32'd1, 5'd8);

    // Reset in the middle of a multiply (count = 10 when enabled).
    in_valid = 1; exe_cmd = 4'd12; branch_type = 0; wb_en = 1;
    alu_inp1 = 32'd9; alu_inp2 = 32'd9; pc = 32'h300; dest = 5'd3;
    repeat (11) @(posedge clock);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1;
    check_reset_state("midrst");
    reset = 1'b0;
    apply(1, 32'h304, 32'h18, 1, 1, 0, 2'd0, 4'd5,
          32'hF0F0F0F0, 32'h0F0F0F0F, 32'd2, 5'd9);

    for (int i = 0; i < 300; i++) begin
      logic v, w, mr, mw;
      logic [1:0] bt;
      logic [3:0] cmd;
      logic [31:0] a, b, r2;
      v  = ($urandom_range(0, 9) != 0);
      w  = 1'($urandom);
      mr = 1'($urandom);
      mw = 1'($urandom);
      if ($urandom_range(0, 99) < 8) begin
        cmd = 4'd12;
        bt  = 2'd0;
      end else begin
        cmd = ops[$urandom_range(0, 11)];
        bt  = 2'($urandom);
      end
      a  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b  = $urandom;
      r2 = ($urandom_range(0, 2) == 0) ? a : $urandom;
      apply(v, $urandom, $urandom, w, mr, mw, bt, cmd,
            a, b, r2, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
